npu_stub_responder: RTL

Cycle-accurate stand-in for the NPU core that terminates both host-side streams. It accepts config and input words from the input-side handler through two write-only FIFOs, executes one simple per-word operation per config command, and presents results through a first-word-fall-through output FIFO drained by the output-side handler. It drops into the top level in place of the NPU with an identical port list, so both handlers can be verified without the neural datapath.

---
 rtl/npu_stub_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/npu_stub_responder.sv
// rtl/npu_stub_responder.sv - NPU stand-in: config/input FIFOs, per-word op FSM, FWFT output FIFO

// Synchronous FIFO with registered occupancy; head word is shown directly (FWFT), zero when empty.
module npu_stub_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push;
  logic          pop;

  // Flags come from the registered count only, so a write racing an internal pop on a full FIFO is dropped.
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];

  // Next pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are meaningless while the count says empty, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end
endmodule

// Top: pops a config, then streams N input words through the selected operation into the output FIFO.
module npu_stub_responder #(
  parameter int IN_DEPTH  = 16,
  parameter int CFG_DEPTH = 16,
  parameter int OUT_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] npu_input_data,
  input  logic        npu_input_fifo_write_enable,
  input  logic [25:0] npu_config_data,
  input  logic        npu_config_fifo_write_enable,
  input  logic        npu_output_fifo_read_enable,
  output logic [31:0] npu_output_data,
  output logic        npu_output_fifo_empty,
  output logic        npu_input_fifo_full,
  output logic        npu_config_fifo_full
);
  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] k_q, k_d;

  logic [25:0] cfg_word;
  logic        cfg_empty;
  logic        cfg_pop;
  logic [31:0] in_word;
  logic        in_empty;
  logic        in_pop;
  logic        out_full;
  logic        out_push;
  logic [31:0] result;

  npu_stub_fifo #(.W(26), .DEPTH(CFG_DEPTH)) u_cfg_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (npu_config_fifo_write_enable),
    .wr_data_i (npu_config_data),
    .rd_en_i   (cfg_pop),
    .rd_data_o (cfg_word),
    .empty_o   (cfg_empty),
    .full_o    (npu_config_fifo_full)
  );

  npu_stub_fifo #(.W(32), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (npu_input_fifo_write_enable),
    .wr_data_i (npu_input_data),
    .rd_en_i   (in_pop),
    .rd_data_o (in_word),
    .empty_o   (in_empty),
    .full_o    (npu_input_fifo_full)
  );

  npu_stub_fifo #(.W(32), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (out_push),
    .wr_data_i (result),
    .rd_en_i   (npu_output_fifo_read_enable),
    .rd_data_o (npu_output_data),
    .empty_o   (npu_output_fifo_empty),
    .full_o    (out_full)
  );

  // Per-word operation selected by the latched command.
  always_comb begin
    result = in_word;
    case (op_q)
      2'b00:   result = in_word;
      2'b01:   result = in_word + {{16{k_q[15]}}, k_q};
      2'b10:   result = in_word << k_q[4:0];
      default: result = 32'd0 - in_word;
    endcase
  end

  // Command sequencing: IDLE pops and latches a config, RUN moves one word per cycle when both FIFOs allow.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    n_d      = n_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    cfg_pop  = 1'b0;
    in_pop   = 1'b0;
    out_push = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!cfg_empty) begin
          cfg_pop = 1'b1;
          op_d    = cfg_word[25:24];
          n_d     = cfg_word[23:16];
          k_d     = cfg_word[15:0];
          cnt_d   = 8'd0;
          // A zero-count command is simply consumed.
          if (cfg_word[23:16] != 8'd0) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!in_empty && !out_full) begin
          in_pop   = 1'b1;
          out_push = 1'b1;
          cnt_d    = cnt_q + 8'd1;
          if (cnt_d == n_q) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and latched command registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      n_q     <= 8'd0;
      k_q     <= 16'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      n_q     <= n_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
